// File: rtl/jtkicker_romarb_pkg.sv
// Shared types and default geometry for the kicker ROM-slot arbiter.
package jtkicker_romarb_pkg;

  localparam int unsigned SCR_AW_DEF   = 13;
  localparam int unsigned OBJ_AW_DEF   = 14;
  localparam int unsigned AW_DEF       = 15;
  localparam int unsigned DW           = 32;
  localparam int unsigned OBJ_BASE_DEF = 32'h2000;

  typedef enum logic [1:0] {IDLE, BUSY, WAIT} state_e;
  typedef enum logic {GNT_SCR, GNT_OBJ} gnt_e;

endpackage

// File: rtl/jtkicker_romarb_if.sv
// Scroll, object and ROM-slot signals between the fetch engines and the arbiter.
interface jtkicker_romarb_if
  import jtkicker_romarb_pkg::*;
#(
  parameter int unsigned SCR_AW = SCR_AW_DEF,
  parameter int unsigned OBJ_AW = OBJ_AW_DEF,
  parameter int unsigned AW     = AW_DEF
) ();

  logic              scr_cs;
  logic [SCR_AW-1:0] scr_addr;
  logic [DW-1:0]     scr_data;
  logic              scr_ok;
  logic              obj_cs;
  logic [OBJ_AW-1:0] obj_addr;
  logic [DW-1:0]     obj_data;
  logic              obj_ok;
  logic              rom_cs;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic              rom_ok;

  modport slave (
    input  scr_cs, scr_addr, obj_cs, obj_addr, rom_data, rom_ok,
    output scr_data, scr_ok, obj_data, obj_ok, rom_cs, rom_addr
  );

  modport master (
    output scr_cs, scr_addr, obj_cs, obj_addr, rom_data, rom_ok,
    input  scr_data, scr_ok, obj_data, obj_ok, rom_cs, rom_addr
  );

endinterface

// File: rtl/jtkicker_romarb_cache.sv
// One-entry read cache: tag/valid/data plus a combinational hit compare.
module jtkicker_romarb_cache
  import jtkicker_romarb_pkg::*;
#(
  parameter int unsigned AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_tag_i,
  input  logic [DW-1:0] fill_data_i,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] data_o,
  output logic          hit_c_o
);

  logic          vld_q;
  logic [AW-1:0] tag_q;
  logic [DW-1:0] data_q;

  // Flush beats a same-cycle fill so a discarded fetch never becomes valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else if (flush_i) begin
      vld_q  <= 1'b0;
    end else if (fill_i) begin
      vld_q  <= 1'b1;
      tag_q  <= fill_tag_i;
      data_q <= fill_data_i;
    end
  end

  assign data_o  = data_q;
  assign hit_c_o = cs_i & vld_q & (tag_q == addr_i);

endmodule

// File: rtl/jtkicker_romarb.sv
// Arbitrates the single 32-bit game ROM slot between scroll and object fetchers.
module jtkicker_romarb
  import jtkicker_romarb_pkg::*;
#(
  parameter int unsigned    SCR_AW   = SCR_AW_DEF,
  parameter int unsigned    OBJ_AW   = OBJ_AW_DEF,
  parameter int unsigned    AW       = AW_DEF,
  parameter logic [AW-1:0]  OBJ_BASE = AW'(OBJ_BASE_DEF),
  parameter int unsigned    OKDLY    = 2,
  parameter int unsigned    STARVE   = 4
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             LHBL,
  input  logic             flush,
  jtkicker_romarb_if.slave bus
);

  localparam int unsigned GW = (OKDLY > 0) ? $clog2(OKDLY + 1) : 1;
  localparam int unsigned SW = $clog2(STARVE + 1);
  localparam int unsigned RW = (SCR_AW > OBJ_AW) ? SCR_AW : OBJ_AW;

  state_e        state_q, state_d;
  gnt_e          gnt_q, gnt_d;
  logic [RW-1:0] req_addr_q, req_addr_d;
  logic          rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [SW-1:0] scr_starve_q, scr_starve_d;
  logic [SW-1:0] obj_starve_q, obj_starve_d;
  logic          drop_q, drop_d;

  logic          scr_hit_c, obj_hit_c;
  logic          scr_miss_c, obj_miss_c;
  logic          scr_fill_c, obj_fill_c;
  logic          pick_obj_c;
  logic [DW-1:0] scr_data, obj_data;

  assign scr_miss_c = bus.scr_cs & ~scr_hit_c;
  assign obj_miss_c = bus.obj_cs & ~obj_hit_c;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    req_addr_d   = req_addr_q;
    rom_cs_d     = rom_cs_q;
    rom_addr_d   = rom_addr_q;
    guard_d      = guard_q;
    scr_starve_d = scr_starve_q;
    obj_starve_d = obj_starve_q;
    drop_d       = drop_q | flush;
    scr_fill_c   = 1'b0;
    obj_fill_c   = 1'b0;
    pick_obj_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (scr_miss_c || obj_miss_c) begin
          // A starved requester overrides the blanking-based priority.
          if (!scr_miss_c)                           pick_obj_c = 1'b1;
          else if (!obj_miss_c)                      pick_obj_c = 1'b0;
          else if (obj_starve_q == SW'(STARVE))      pick_obj_c = 1'b1;
          else if (scr_starve_q == SW'(STARVE))      pick_obj_c = 1'b0;
          else                                       pick_obj_c = ~LHBL;

          if (pick_obj_c) begin
            gnt_d        = GNT_OBJ;
            req_addr_d   = RW'(bus.obj_addr);
            rom_addr_d   = OBJ_BASE + AW'(bus.obj_addr);
            obj_starve_d = '0;
            if (scr_miss_c && scr_starve_q != SW'(STARVE))
              scr_starve_d = scr_starve_q + SW'(1);
          end else begin
            gnt_d        = GNT_SCR;
            req_addr_d   = RW'(bus.scr_addr);
            rom_addr_d   = AW'(bus.scr_addr);
            scr_starve_d = '0;
            if (obj_miss_c && obj_starve_q != SW'(STARVE))
              obj_starve_d = obj_starve_q + SW'(1);
          end
          rom_cs_d = 1'b1;
          guard_d  = GW'(OKDLY);
          drop_d   = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // rom_ok lags a new address, so it is ignored until the guard expires.
        if (guard_q != '0) begin
          guard_d = guard_q - GW'(1);
        end else if (bus.rom_ok) begin
          scr_fill_c = (gnt_q == GNT_SCR) & ~drop_q;
          obj_fill_c = (gnt_q == GNT_OBJ) & ~drop_q;
          rom_cs_d   = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_SCR;
      req_addr_q   <= '0;
      rom_cs_q     <= 1'b0;
      rom_addr_q   <= '0;
      guard_q      <= '0;
      scr_starve_q <= '0;
      obj_starve_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      req_addr_q   <= req_addr_d;
      rom_cs_q     <= rom_cs_d;
      rom_addr_q   <= rom_addr_d;
      guard_q      <= guard_d;
      scr_starve_q <= scr_starve_d;
      obj_starve_q <= obj_starve_d;
      drop_q       <= drop_d;
    end
  end

  jtkicker_romarb_cache #(.AW(SCR_AW)) u_scr_cache (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .fill_i      (scr_fill_c),
    .fill_tag_i  (req_addr_q[SCR_AW-1:0]),
    .fill_data_i (bus.rom_data),
    .cs_i        (bus.scr_cs),
    .addr_i      (bus.scr_addr),
    .data_o      (scr_data),
    .hit_c_o     (scr_hit_c)
  );

  jtkicker_romarb_cache #(.AW(OBJ_AW)) u_obj_cache (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .fill_i      (obj_fill_c),
    .fill_tag_i  (req_addr_q[OBJ_AW-1:0]),
    .fill_data_i (bus.rom_data),
    .cs_i        (bus.obj_cs),
    .addr_i      (bus.obj_addr),
    .data_o      (obj_data),
    .hit_c_o     (obj_hit_c)
  );

  assign bus.scr_data = scr_data;
  assign bus.scr_ok   = scr_hit_c;
  assign bus.obj_data = obj_data;
  assign bus.obj_ok   = obj_hit_c;
  assign bus.rom_cs   = rom_cs_q;
  assign bus.rom_addr = rom_addr_q;

endmodule

// File: tb/tb_jtkicker_romarb.sv
// Bench for jtkicker_romarb: directed scenarios, then random traffic against
// rule-level properties (data matches ROM contents, grants, spacing, liveness).
module tb_jtkicker_romarb;

  localparam int unsigned SCR_AW = 13;
  localparam int unsigned OBJ_AW = 14;
  localparam int unsigned AW     = 15;
  localparam int unsigned OKDLY  = 2;
  localparam int unsigned STARVE = 4;
  localparam int          LIMIT  = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic LHBL = 1'b1;
  logic flush = 1'b0;

  jtkicker_romarb_if #(.SCR_AW(SCR_AW), .OBJ_AW(OBJ_AW), .AW(AW)) bus ();

  jtkicker_romarb #(
    .SCR_AW(SCR_AW), .OBJ_AW(OBJ_AW), .AW(AW),
    .OBJ_BASE(15'h2000), .OKDLY(OKDLY), .STARVE(STARVE)
  ) dut (
    .rst   (rst),
    .clk   (clk),
    .LHBL  (LHBL),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ROM contents and address map, from first principles.
  function automatic logic [31:0] romf(input logic [AW-1:0] a);
    return {a, 17'h0} ^ (32'(a) * 32'h9E37_79B1) ^ 32'h1357_0000;
  endfunction

  function automatic logic [AW-1:0] obj_rom(input logic [OBJ_AW-1:0] a);
    return AW'((32'(a) + 32'h2000) % 32'h8000);
  endfunction

  // ROM slot model: data becomes correct OKDLY cycles after the address settles.
  int          rom_age = 0;
  int          rom_lat = 2;
  logic [AW-1:0] rom_last = '0;
  logic        rom_last_cs = 1'b0;
  bit          rom_always = 1'b0;
  bit          rnd_lat = 1'b0;

  always @(negedge clk) begin
    if (bus.rom_cs && rom_last_cs && bus.rom_addr == rom_last) rom_age++;
    else begin
      rom_age = 0;
      rom_lat = rnd_lat ? int'($urandom_range(4, 2)) : int'(OKDLY);
    end
    rom_last    = bus.rom_addr;
    rom_last_cs = bus.rom_cs;
    bus.rom_data = (bus.rom_cs && rom_age >= int'(OKDLY)) ? romf(bus.rom_addr) : 32'hBAD0_BAD0;
    bus.rom_ok   = rom_always || (bus.rom_cs && rom_age >= rom_lat);
  end

  task automatic fetch(input bit is_obj, output logic [AW-1:0] ra, output int n);
    bit seen = 1'b0;
    n  = 0;
    ra = '0;
    while (!(is_obj ? bus.obj_ok : bus.scr_ok) && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.rom_cs && !seen) begin
        seen = 1'b1;
        ra   = bus.rom_addr;
      end
    end
  endtask

  task automatic wait_grant(input string tag, output logic [AW-1:0] ra);
    int n = 0;
    while (!bus.rom_cs && n < 60) begin
      @(negedge clk);
      n++;
    end
    ra = bus.rom_addr;
    check({tag, "_grant"}, 32'(bus.rom_cs), 32'd1);
  endtask

  task automatic wait_fall(output int ok_seen);
    int n = 0;
    ok_seen = 0;
    while (bus.rom_cs && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.scr_ok) ok_seen++;
    end
  endtask

  logic [AW-1:0] ra;
  int            n, oks, scr_grants, sw, ow, max_w, last_rise;
  bit            got_obj, prev_cs, prev_flush;
  logic [AW-1:0] prev_addr;

  initial begin
    bus.scr_cs = 1'b0; bus.scr_addr = '0;
    bus.obj_cs = 1'b0; bus.obj_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_rom_cs",   32'(bus.rom_cs),   32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_scr_data", bus.scr_data,      32'd0);
    check("rst_obj_data", bus.obj_data,      32'd0);
    check("rst_scr_ok",   32'(bus.scr_ok),   32'd0);
    check("rst_obj_ok",   32'(bus.obj_ok),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single scroll miss; latency counts the request cycle and the first ok cycle.
    bus.scr_addr = 13'h0123; bus.scr_cs = 1'b1;
    fetch(1'b0, ra, n);
    check("t1_rom_addr", 32'(ra), 32'h0123);
    check("t1_latency",  32'(n + 1), 32'(OKDLY + 3));
    check("t1_data",     bus.scr_data, romf(15'h0123));
    @(negedge clk);
    bus.scr_cs = 1'b0; #1;
    check("t1_idle_ok",   32'(bus.scr_ok), 32'd0);
    check("t1_idle_data", bus.scr_data, romf(15'h0123));
    bus.scr_cs = 1'b1; #1;
    check("t1_rehit", 32'(bus.scr_ok), 32'd1);
    bus.scr_cs = 1'b0;

    // Object window mapping.
    @(negedge clk);
    bus.obj_addr = 14'h3FFF; bus.obj_cs = 1'b1;
    fetch(1'b1, ra, n);
    check("t2_rom_addr", 32'(ra), 32'(obj_rom(14'h3FFF)));
    check("t2_data",     bus.obj_data, romf(15'h5FFF));
    bus.obj_cs = 1'b0;

    // Contention: blanking picks obj, active line picks scroll.
    for (int k = 0; k < 2; k++) begin
      repeat (3) @(negedge clk);
      LHBL = (k == 1);
      bus.scr_addr = SCR_AW'(13'h0200 + k); bus.obj_addr = OBJ_AW'(14'h0300 + k);
      bus.scr_cs = 1'b1; bus.obj_cs = 1'b1;
      wait_grant("t3", ra);
      check("t3_first", 32'(ra), (k == 1) ? 32'(13'h0200 + k) : 32'(obj_rom(OBJ_AW'(14'h0300 + k))));
      n = 0;
      while (!(bus.scr_ok && bus.obj_ok) && n < 80) begin @(negedge clk); n++; end
      check("t3_both_ok", 32'(bus.scr_ok && bus.obj_ok), 32'd1);
      bus.scr_cs = 1'b0; bus.obj_cs = 1'b0;
    end

    // Starvation: scroll keeps priority and keeps missing; obj must break through.
    repeat (3) @(negedge clk);
    LHBL = 1'b1;
    bus.obj_addr = 14'h0400; bus.scr_addr = 13'h0500;
    bus.obj_cs = 1'b1; bus.scr_cs = 1'b1;
    scr_grants = 0; got_obj = 1'b0; prev_cs = bus.rom_cs;
    for (int i = 0; i < 400 && !bus.obj_ok; i++) begin
      @(negedge clk);
      if (bus.rom_cs && !prev_cs && !got_obj) begin
        if (bus.rom_addr == obj_rom(14'h0400)) got_obj = 1'b1;
        else scr_grants++;
      end
      prev_cs = bus.rom_cs;
      if (bus.scr_ok) bus.scr_addr = bus.scr_addr + 13'd1;
    end
    check("starve_scr_grants", 32'(scr_grants), 32'(STARVE));
    check("starve_obj_ok",     32'(bus.obj_ok), 32'd1);
    bus.obj_cs = 1'b0; bus.scr_cs = 1'b0;
    repeat (10) @(negedge clk);

    // rom_ok held high from the start: capture must wait for the guard.
    rom_always = 1'b1;
    bus.scr_addr = 13'h0777; bus.scr_cs = 1'b1;
    fetch(1'b0, ra, n);
    check("t5_data",    bus.scr_data, romf(15'h0777));
    check("t5_latency", 32'(n + 1), 32'(OKDLY + 3));
    rom_always = 1'b0;
    @(negedge clk);

    // Address change mid-fetch: fill keeps the latched tag, then a second fetch.
    bus.scr_addr = 13'h0010;
    wait_grant("t6", ra);
    check("t6_rom_addr", 32'(ra), 32'h0010);
    bus.scr_addr = 13'h0011;
    wait_fall(oks);
    check("t6_no_ok", 32'(oks), 32'd0);
    bus.scr_addr = 13'h0010; #1;
    check("t6_old_tag_ok",   32'(bus.scr_ok), 32'd1);
    check("t6_old_tag_data", bus.scr_data, romf(15'h0010));
    bus.scr_addr = 13'h0011;
    wait_grant("t6b", ra);
    check("t6_refetch_addr", 32'(ra), 32'h0011);
    fetch(1'b0, ra, n);
    check("t6_new_data", bus.scr_data, romf(15'h0011));

    // Flush mid-fetch discards the fill and the previously valid entry.
    bus.scr_addr = 13'h0020;
    wait_grant("t7", ra);
    check("t7_rom_addr", 32'(ra), 32'h0020);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_fall(oks);
    check("t7_no_ok", 32'(oks), 32'd0);
    bus.scr_addr = 13'h0011; #1;
    check("t7_old_gone", 32'(bus.scr_ok), 32'd0);
    bus.scr_addr = 13'h0020;
    wait_grant("t7b", ra);
    check("t7_refetch_addr", 32'(ra), 32'h0020);
    fetch(1'b0, ra, n);
    check("t7_data", bus.scr_data, romf(15'h0020));

    // Asynchronous reset in the middle of a fetch.
    @(negedge clk);
    bus.scr_addr = 13'h0030;
    wait_grant("t8", ra);
    rst = 1'b1; #1;
    check("t8_rom_cs",   32'(bus.rom_cs),   32'd0);
    check("t8_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("t8_scr_data", bus.scr_data,      32'd0);
    check("t8_scr_ok",   32'(bus.scr_ok),   32'd0);
    @(negedge clk);
    rst = 1'b0; bus.scr_cs = 1'b0;
    repeat (2) @(negedge clk);

    // Random traffic.
    rnd_lat = 1'b1;
    prev_cs = bus.rom_cs; prev_addr = bus.rom_addr; prev_flush = 1'b0;
    last_rise = -100; sw = 0; ow = 0; max_w = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (prev_flush) begin
        check("rnd_flush_scr", 32'(bus.scr_ok), 32'd0);
        check("rnd_flush_obj", 32'(bus.obj_ok), 32'd0);
      end
      if (bus.rom_cs && !prev_cs) begin
        check("rnd_grant", 32'((bus.scr_cs && bus.rom_addr == AW'(bus.scr_addr)) ||
                               (bus.obj_cs && bus.rom_addr == obj_rom(bus.obj_addr))), 32'd1);
        check("rnd_gap", 32'(cyc - last_rise >= int'(OKDLY) + 3), 32'd1);
        last_rise = cyc;
      end
      if (bus.rom_cs && prev_cs) check("rnd_addr_hold", 32'(bus.rom_addr), 32'(prev_addr));
      if (bus.scr_ok) check("rnd_scr_data", bus.scr_data, romf(AW'(bus.scr_addr)));
      if (bus.obj_ok) check("rnd_obj_data", bus.obj_data, romf(obj_rom(bus.obj_addr)));
      if (!bus.scr_cs) check("rnd_scr_idle", 32'(bus.scr_ok), 32'd0);
      if (!bus.obj_cs) check("rnd_obj_idle", 32'(bus.obj_ok), 32'd0);
      sw = (bus.scr_cs && !bus.scr_ok) ? sw + 1 : 0;
      ow = (bus.obj_cs && !bus.obj_ok) ? ow + 1 : 0;
      if (sw > max_w) max_w = sw;
      if (ow > max_w) max_w = ow;
      prev_cs = bus.rom_cs; prev_addr = bus.rom_addr;

      if (!bus.scr_cs) begin
        if ($urandom_range(3) == 0) begin
          bus.scr_cs = 1'b1; bus.scr_addr = SCR_AW'($urandom_range(7) * 32'h0111); sw = 0;
        end
      end else if (bus.scr_ok || $urandom_range(31) == 0) begin
        if ($urandom_range(1) == 0) bus.scr_cs = 1'b0;
        else bus.scr_addr = SCR_AW'($urandom_range(7) * 32'h0111);
        sw = 0;
      end
      if (!bus.obj_cs) begin
        if ($urandom_range(3) == 0) begin
          bus.obj_cs = 1'b1; bus.obj_addr = OBJ_AW'($urandom_range(7) * 32'h0523 + 32'h3F00); ow = 0;
        end
      end else if (bus.obj_ok || $urandom_range(31) == 0) begin
        if ($urandom_range(1) == 0) bus.obj_cs = 1'b0;
        else bus.obj_addr = OBJ_AW'($urandom_range(7) * 32'h0523 + 32'h3F00);
        ow = 0;
      end
      if ($urandom_range(15) == 0) LHBL = ~LHBL;
      flush = ($urandom_range(63) == 0);
      prev_flush = flush;
    end
    check("rnd_max_wait", 32'(max_w <= LIMIT), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
